// File: rtl/vga_pkg.sv
// Shared types for the VGA capture path: colour codes, their 12-bit RGB values
// and the receiver lock-state encoding.
package vga_pkg;

  localparam int RGB_W = 12;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_e;

  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] RGB_WHITE = 12'hFFF;
  localparam logic [RGB_W-1:0] RGB_BLUE  = 12'hF00;
  localparam logic [RGB_W-1:0] RGB_GREEN = 12'h0F0;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic   unknown;
    color_e color;
  } color_dec_t;

  function automatic color_dec_t decode_color(input logic [RGB_W-1:0] rgb);
    color_dec_t dec;
    dec.unknown = 1'b0;
    dec.color   = BLACK;
    case (rgb)
      RGB_BLACK: dec.color = BLACK;
      RGB_WHITE: dec.color = WHITE;
      RGB_BLUE:  dec.color = BLUE;
      RGB_GREEN: dec.color = GREEN;
      default: begin
        dec.unknown = 1'b1;
        dec.color   = BLACK;
      end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/vga_rx_sync_tracker.sv
// Input capture stage of vga_rx: registers sync/RGB, tracks the beam position
// (hcnt/vcnt of the pixel currently in rgb_q) and flags timing violations.
module vga_rx_sync_tracker
  import vga_pkg::*;
#(
  parameter int HSYNC_BITS = 11,
  parameter int VSYNC_BITS = 11,
  parameter int HMAX       = 1687,
  parameter int HR         = 112,
  parameter int VMAX       = 1065,
  parameter int VR         = 3
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  hs,
  input  logic                  vs,
  input  logic [RGB_W-1:0]      rgb,
  output logic [RGB_W-1:0]      rgb_q,
  output logic                  frame_start,
  output logic [HSYNC_BITS-1:0] hcnt,
  output logic [VSYNC_BITS-1:0] vcnt,
  output logic                  violation
);

  localparam logic [HSYNC_BITS-1:0] HMAX_C = HSYNC_BITS'(HMAX);
  localparam logic [HSYNC_BITS-1:0] HR_C   = HSYNC_BITS'(HR);
  localparam logic [HSYNC_BITS-1:0] H_SAT  = {HSYNC_BITS{1'b1}};
  localparam logic [VSYNC_BITS-1:0] VMAX_C = VSYNC_BITS'(VMAX);
  localparam logic [VSYNC_BITS-1:0] VR_C   = VSYNC_BITS'(VR);
  localparam logic [VSYNC_BITS-1:0] V_SAT  = {VSYNC_BITS{1'b1}};

  logic                  hs_q_r, hs_d_r, vs_q_r, vs_d_r;
  logic [RGB_W-1:0]      rgb_q_r;
  logic [HSYNC_BITS-1:0] hcnt_r, hcnt_s;
  logic [VSYNC_BITS-1:0] vcnt_r, vcnt_s;
  logic                  hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s, frame_start_s;
  logic                  violation_s;

  assign hs_rise_s     = hs_q_r & ~hs_d_r;
  assign hs_fall_s     = ~hs_q_r & hs_d_r;
  assign vs_rise_s     = vs_q_r & ~vs_d_r;
  assign vs_fall_s     = ~vs_q_r & vs_d_r;
  assign frame_start_s = vs_rise_s & hs_rise_s;

  // Capture registers, edge-detect delay taps and the position counters.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hs_q_r  <= 1'b0;
      hs_d_r  <= 1'b0;
      vs_q_r  <= 1'b0;
      vs_d_r  <= 1'b0;
      rgb_q_r <= {RGB_W{1'b0}};
      hcnt_r  <= {HSYNC_BITS{1'b0}};
      vcnt_r  <= {VSYNC_BITS{1'b0}};
    end else begin
      hs_q_r  <= hs;
      hs_d_r  <= hs_q_r;
      vs_q_r  <= vs;
      vs_d_r  <= vs_q_r;
      rgb_q_r <= rgb;
      hcnt_r  <= hcnt_s;
      vcnt_r  <= vcnt_s;
    end
  end

  // Position of the pixel now in rgb_q; hcnt_r/vcnt_r hold the previous one.
  always_comb begin
    hcnt_s = hcnt_r;
    vcnt_s = vcnt_r;
    if (hs_rise_s) begin
      hcnt_s = {HSYNC_BITS{1'b0}};
    end else if (hcnt_r != H_SAT) begin
      hcnt_s = hcnt_r + HSYNC_BITS'(1);
    end else begin
      hcnt_s = hcnt_r;
    end
    if (frame_start_s) begin
      vcnt_s = {VSYNC_BITS{1'b0}};
    end else if (hs_rise_s && (vcnt_r != V_SAT)) begin
      vcnt_s = vcnt_r + VSYNC_BITS'(1);
    end else begin
      vcnt_s = vcnt_r;
    end
  end

  // Timing checks against the configured mode; saturation flags once on arrival.
  always_comb begin
    violation_s = 1'b0;
    if ((hs_rise_s && (hcnt_r != HMAX_C)) ||
        (hs_fall_s && (hcnt_s != HR_C)) ||
        (frame_start_s && (vcnt_r != VMAX_C)) ||
        (vs_fall_s != (hs_rise_s && (vcnt_s == VR_C))) ||
        (vs_rise_s && !hs_rise_s) ||
        ((hcnt_s == H_SAT) && (hcnt_r != H_SAT)) ||
        ((vcnt_s == V_SAT) && (vcnt_r != V_SAT))) begin
      violation_s = 1'b1;
    end else begin
      violation_s = 1'b0;
    end
  end

  assign rgb_q       = rgb_q_r;
  assign frame_start = frame_start_s;
  assign hcnt        = hcnt_s;
  assign vcnt        = vcnt_s;
  assign violation   = violation_s;

endmodule

// File: rtl/vga_rx.sv
// VGA capture front end: locks onto verified sync timing, then emits one
// (x, y, colour) beat per active-area pixel two cycles after it was sampled.
module vga_rx
  import vga_pkg::*;
#(
  parameter int HSYNC_BITS = 11,
  parameter int VSYNC_BITS = 11,
  parameter int HD = 1280,
  parameter int HF = 48,
  parameter int HR = 112,
  parameter int HB = 248,
  parameter int VD = 1024,
  parameter int VF = 1,
  parameter int VR = 3,
  parameter int VB = 38,
  parameter int H_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  vga_hs_i,
  input  logic                  vga_vs_i,
  input  logic [11:0]           rgb_i,
  output logic                  locked_o,
  output logic                  px_valid_o,
  output logic [HSYNC_BITS-1:0] px_x_o,
  output logic [VSYNC_BITS-1:0] px_y_o,
  output logic [1:0]            px_color_o,
  output logic                  px_unknown_o,
  output logic                  frame_start_o,
  output logic                  sync_err_o,
  output logic [7:0]            err_cnt_o
);

  localparam int HMAX = HD + HF + HR + HB - 1;
  localparam int VMAX = VD + VF + VR + VB - 1;
  localparam logic [HSYNC_BITS-1:0] X_LO = HSYNC_BITS'(HR + HB + H_OFFSET);
  localparam logic [HSYNC_BITS-1:0] X_HI = HSYNC_BITS'(HR + HB + H_OFFSET + HD);
  localparam logic [VSYNC_BITS-1:0] Y_LO = VSYNC_BITS'(VR + VB);
  localparam logic [VSYNC_BITS-1:0] Y_HI = VSYNC_BITS'(VR + VB + VD);

  logic [RGB_W-1:0]      rgb_q_s;
  logic                  frame_start_s, violation_s;
  logic [HSYNC_BITS-1:0] hcnt_s;
  logic [VSYNC_BITS-1:0] vcnt_s;
  logic                  active_s, counted_s, lock_next_s;
  color_dec_t            dec_s;

  rx_state_e             state_r;
  logic                  locked_r, px_valid_r, px_unknown_r, frame_start_r, sync_err_r;
  logic [HSYNC_BITS-1:0] px_x_r;
  logic [VSYNC_BITS-1:0] px_y_r;
  color_e                px_color_r;
  logic [7:0]            err_cnt_r;

  vga_rx_sync_tracker #(
    .HSYNC_BITS (HSYNC_BITS),
    .VSYNC_BITS (VSYNC_BITS),
    .HMAX       (HMAX),
    .HR         (HR),
    .VMAX       (VMAX),
    .VR         (VR)
  ) u_tracker (
    .clk         (clk),
    .arstn       (arstn),
    .hs          (vga_hs_i),
    .vs          (vga_vs_i),
    .rgb         (rgb_i),
    .rgb_q       (rgb_q_s),
    .frame_start (frame_start_s),
    .hcnt        (hcnt_s),
    .vcnt        (vcnt_s),
    .violation   (violation_s)
  );

  assign dec_s     = decode_color(rgb_q_s);
  assign active_s  = (hcnt_s >= X_LO) && (hcnt_s < X_HI) && (vcnt_s >= Y_LO) && (vcnt_s < Y_HI);
  assign counted_s = violation_s && (state_r != SEARCH);

  // Whether the FSM is LOCKED after this edge; a violation always wins.
  always_comb begin
    lock_next_s = 1'b0;
    case (state_r)
      SEARCH:  lock_next_s = 1'b0;
      MEASURE: lock_next_s = frame_start_s && !violation_s;
      LOCKED:  lock_next_s = !violation_s;
      default: lock_next_s = 1'b0;
    endcase
  end

  // Lock FSM plus all registered outputs.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r       <= SEARCH;
      locked_r      <= 1'b0;
      px_valid_r    <= 1'b0;
      px_unknown_r  <= 1'b0;
      px_x_r        <= {HSYNC_BITS{1'b0}};
      px_y_r        <= {VSYNC_BITS{1'b0}};
      px_color_r    <= BLACK;
      frame_start_r <= 1'b0;
      sync_err_r    <= 1'b0;
      err_cnt_r     <= 8'd0;
    end else begin
      case (state_r)
        SEARCH: begin
          if (frame_start_s) state_r <= MEASURE;
        end
        MEASURE: begin
          if (violation_s)        state_r <= SEARCH;
          else if (frame_start_s) state_r <= LOCKED;
        end
        LOCKED: begin
          if (violation_s) state_r <= SEARCH;
        end
        default: state_r <= SEARCH;
      endcase
      locked_r      <= lock_next_s;
      frame_start_r <= frame_start_s;
      sync_err_r    <= counted_s;
      if (counted_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
      px_valid_r    <= active_s && lock_next_s;
      px_unknown_r  <= active_s && lock_next_s && dec_s.unknown;
      if (active_s) begin
        px_x_r     <= hcnt_s - X_LO;
        px_y_r     <= vcnt_s - Y_LO;
        px_color_r <= dec_s.color;
      end
    end
  end

  assign locked_o      = locked_r;
  assign px_valid_o    = px_valid_r;
  assign px_x_o        = px_x_r;
  assign px_y_o        = px_y_r;
  assign px_color_o    = px_color_r;
  assign px_unknown_o  = px_unknown_r;
  assign frame_start_o = frame_start_r;
  assign sync_err_o    = sync_err_r;
  assign err_cnt_o     = err_cnt_r;

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx in a small 15-cycle x 8-line mode (8x4 active area).
module tb_vga_rx;

  localparam int LINE   = 15;
  localparam int NLINES = 8;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        vga_hs_i = 1'b0;
  logic        vga_vs_i = 1'b0;
  logic [11:0] rgb_i = 12'h000;
  logic        locked_o, px_valid_o, px_unknown_o, frame_start_o, sync_err_o;
  logic [10:0] px_x_o, px_y_o;
  logic [1:0]  px_color_o;
  logic [7:0]  err_cnt_o;

  vga_rx #(
    .HD(8), .HF(2), .HR(2), .HB(3), .VD(4), .VF(1), .VR(1), .VB(2), .H_OFFSET(0)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .vga_hs_i      (vga_hs_i),
    .vga_vs_i      (vga_vs_i),
    .rgb_i         (rgb_i),
    .locked_o      (locked_o),
    .px_valid_o    (px_valid_o),
    .px_x_o        (px_x_o),
    .px_y_o        (px_y_o),
    .px_color_o    (px_color_o),
    .px_unknown_o  (px_unknown_o),
    .frame_start_o (frame_start_o),
    .sync_err_o    (sync_err_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: running tallies that the scenario tasks difference.
  int   beat_cnt = 0, sum_x = 0, sum_y = 0, bad_col = 0, uk_cnt = 0;
  int   fs_cnt = 0, se_cnt = 0, se_cyc = 0, se_valid = 0, lock_fs = 0;
  int   rec52_cyc = 0;
  logic lock_with_fs = 1'b0, locked_prev = 1'b0;
  logic [1:0] rec52_col = 2'd0;
  logic [1:0] exp_color = 2'd0;
  logic exp_chk = 1'b0;

  always @(negedge clk) begin
    if (frame_start_o) fs_cnt <= fs_cnt + 1;
    if (sync_err_o) begin
      se_cnt <= se_cnt + 1;
      se_cyc <= cyc;
      if (px_valid_o) se_valid <= se_valid + 1;
    end
    if (locked_o && !locked_prev) begin
      lock_fs      <= fs_cnt + (frame_start_o ? 1 : 0);
      lock_with_fs <= frame_start_o;
    end
    locked_prev <= locked_o;
    if (px_valid_o) begin
      beat_cnt <= beat_cnt + 1;
      sum_x    <= sum_x + int'(px_x_o);
      sum_y    <= sum_y + int'(px_y_o);
      if (exp_chk && (px_color_o != exp_color)) bad_col <= bad_col + 1;
      if (px_unknown_o) uk_cnt <= uk_cnt + 1;
      if ((px_x_o == 11'd5) && (px_y_o == 11'd2)) begin
        rec52_cyc <= cyc;
        rec52_col <= px_color_o;
      end
    end
  end

  // Stimulus
  int in_cyc = 0;
  int mark_l = -1;
  int mark_c = -1;

  task automatic step(input logic hs, input logic vs, input logic [11:0] rgb);
    vga_hs_i = hs;
    vga_vs_i = vs;
    rgb_i    = rgb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pix(input int pat, input int l, input int c);
    logic [3:0] cn, ln;
    cn = c[3:0];
    ln = l[3:0];
    case (pat)
      0: return 12'h0F0;
      1: return ((l == 5) && (c == 10)) ? 12'hF00 : {cn, ln, 4'h5};
      2: return 12'h123;
      default: return 12'h000;
    endcase
  endfunction

  // Emit the frame positions from (l0,c0) to (l1,c1) inclusive.
  task automatic send_seg(input int pat, input int short_line, input int vs_lines,
                          input int l0, input int c0, input int l1, input int c1);
    for (int l = 0; l < NLINES; l++) begin
      for (int c = 0; c < ((l == short_line) ? LINE - 1 : LINE); c++) begin
        if (((l > l0) || ((l == l0) && (c >= c0))) && ((l < l1) || ((l == l1) && (c <= c1)))) begin
          if ((l == mark_l) && (c == mark_c)) in_cyc = cyc;
          step(c < 2, l < vs_lines, pix(pat, l, c));
        end
      end
    end
  endtask

  task automatic send_frame(input int pat, input int short_line, input int vs_lines);
    send_seg(pat, short_line, vs_lines, 0, 0, NLINES - 1, LINE);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b0, 1'b0, 12'h000);
    checks++;
    if ({locked_o, px_valid_o, px_unknown_o, frame_start_o, sync_err_o, err_cnt_o, px_x_o, px_y_o, px_color_o} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got lock=%b val=%b err_cnt=%0d expected all zero", locked_o, px_valid_o, err_cnt_o);
    end
    arstn = 1'b1;
    repeat (2) step(1'b0, 1'b0, 12'h000);
    checks++;
    if ({locked_o, px_valid_o, sync_err_o, err_cnt_o} !== 11'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got lock=%b val=%b err_cnt=%0d expected zero", locked_o, px_valid_o, err_cnt_o);
    end
  endtask

  task automatic test_lock_green();
    int fs0, b0, sx0, sy0, bc0, uk0, se0;
    exp_color = 2'd3;
    exp_chk   = 1'b1;
    fs0 = fs_cnt; b0 = beat_cnt; se0 = se_cnt;
    send_frame(0, -1, 1);
    checks++;
    if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_f1_locked: got %b expected 0", locked_o); end
    checks++;
    if (beat_cnt - b0 != 0) begin errors++; $display("FAIL lock_f1_beats: got %0d expected 0", beat_cnt - b0); end
    b0 = beat_cnt; sx0 = sum_x; sy0 = sum_y;
    send_frame(0, -1, 1);
    checks++;
    if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_f2_locked: got %b expected 1", locked_o); end
    checks++;
    if ((lock_fs - fs0 != 2) || (lock_with_fs !== 1'b1)) begin
      errors++;
      $display("FAIL lock_at_fs: got fs#%0d same_cycle=%b expected fs#2 same_cycle=1", lock_fs - fs0, lock_with_fs);
    end
    checks++;
    if (beat_cnt - b0 != 32) begin errors++; $display("FAIL lock_f2_beats: got %0d expected 32", beat_cnt - b0); end
    checks++;
    if ((sum_x - sx0 != 112) || (sum_y - sy0 != 48)) begin
      errors++;
      $display("FAIL lock_f2_xy_sum: got x=%0d y=%0d expected x=112 y=48", sum_x - sx0, sum_y - sy0);
    end
    b0 = beat_cnt; bc0 = bad_col; uk0 = uk_cnt;
    send_frame(0, -1, 1);
    checks++;
    if ((beat_cnt - b0 != 32) || (bad_col - bc0 != 0) || (uk_cnt - uk0 != 0)) begin
      errors++;
      $display("FAIL lock_f3_green: got beats=%0d badcol=%0d unknown=%0d expected 32 0 0", beat_cnt - b0, bad_col - bc0, uk_cnt - uk0);
    end
    checks++;
    if ((se_cnt - se0 != 0) || (err_cnt_o !== 8'd0)) begin
      errors++;
      $display("FAIL lock_no_errors: got pulses=%0d err_cnt=%0d expected 0 0", se_cnt - se0, err_cnt_o);
    end
  endtask

  task automatic test_pixel();
    int b0, uk0;
    exp_chk = 1'b0;
    mark_l = 5; mark_c = 10;
    b0 = beat_cnt; uk0 = uk_cnt;
    send_frame(1, -1, 1);
    mark_l = -1; mark_c = -1;
    checks++;
    if (rec52_cyc != in_cyc + 2) begin errors++; $display("FAIL pixel_latency: got %0d expected %0d", rec52_cyc - in_cyc, 2); end
    checks++;
    if (rec52_col !== 2'd2) begin errors++; $display("FAIL pixel_color: got %0d expected 2", rec52_col); end
    checks++;
    if ((beat_cnt - b0 != 32) || (uk_cnt - uk0 != 31)) begin
      errors++;
      $display("FAIL pixel_gradient: got beats=%0d unknown=%0d expected 32 31", beat_cnt - b0, uk_cnt - uk0);
    end
  endtask

  task automatic test_short_line();
    int b0, se0, sv0, fs0;
    exp_color = 2'd3; exp_chk = 1'b1;
    mark_l = 5; mark_c = 0;
    b0 = beat_cnt; se0 = se_cnt; sv0 = se_valid;
    send_frame(0, 4, 1);
    mark_l = -1; mark_c = -1;
    checks++;
    if ((se_cnt - se0 != 1) || (se_cyc != in_cyc + 2)) begin
      errors++;
      $display("FAIL short_pulse: got pulses=%0d offset=%0d expected 1 2", se_cnt - se0, se_cyc - in_cyc);
    end
    checks++;
    if ((err_cnt_o !== 8'd1) || (locked_o !== 1'b0)) begin
      errors++;
      $display("FAIL short_state: got err_cnt=%0d lock=%b expected 1 0", err_cnt_o, locked_o);
    end
    checks++;
    if ((beat_cnt - b0 != 16) || (se_valid - sv0 != 0)) begin
      errors++;
      $display("FAIL short_beats: got beats=%0d valid_at_err=%0d expected 16 0", beat_cnt - b0, se_valid - sv0);
    end
    fs0 = fs_cnt; b0 = beat_cnt;
    send_frame(0, -1, 1);
    checks++;
    if ((locked_o !== 1'b0) || (beat_cnt - b0 != 0)) begin
      errors++;
      $display("FAIL short_relock_a: got lock=%b beats=%0d expected 0 0", locked_o, beat_cnt - b0);
    end
    b0 = beat_cnt;
    send_frame(0, -1, 1);
    checks++;
    if ((locked_o !== 1'b1) || (lock_fs - fs0 != 2) || (beat_cnt - b0 != 32) || (err_cnt_o !== 8'd1)) begin
      errors++;
      $display("FAIL short_relock_b: got lock=%b fs#%0d beats=%0d err_cnt=%0d expected 1 2 32 1", locked_o, lock_fs - fs0, beat_cnt - b0, err_cnt_o);
    end
  endtask

  task automatic test_vs_long();
    int b0, se0;
    mark_l = 1; mark_c = 0;
    b0 = beat_cnt; se0 = se_cnt;
    send_frame(0, -1, 2);
    checks++;
    if ((se_cnt - se0 != 1) || (se_cyc != in_cyc + 2) || (err_cnt_o !== 8'd2)) begin
      errors++;
      $display("FAIL vs_long_locked: got pulses=%0d offset=%0d err_cnt=%0d expected 1 2 2", se_cnt - se0, se_cyc - in_cyc, err_cnt_o);
    end
    se0 = se_cnt;
    send_frame(0, -1, 2);
    mark_l = -1; mark_c = -1;
    checks++;
    if ((se_cnt - se0 != 1) || (se_cyc != in_cyc + 2) || (err_cnt_o !== 8'd3) || (locked_o !== 1'b0)) begin
      errors++;
      $display("FAIL vs_long_measure: got pulses=%0d offset=%0d err_cnt=%0d lock=%b expected 1 2 3 0", se_cnt - se0, se_cyc - in_cyc, err_cnt_o, locked_o);
    end
    send_frame(0, -1, 1);
    checks++;
    if ((locked_o !== 1'b0) || (beat_cnt - b0 != 0)) begin
      errors++;
      $display("FAIL vs_long_still_measuring: got lock=%b beats=%0d expected 0 0", locked_o, beat_cnt - b0);
    end
    send_frame(0, -1, 1);
    checks++;
    if ((locked_o !== 1'b1) || (beat_cnt - b0 != 32)) begin
      errors++;
      $display("FAIL vs_long_relock: got lock=%b beats=%0d expected 1 32", locked_o, beat_cnt - b0);
    end
  endtask

  task automatic test_unknown();
    int b0, uk0, bc0;
    exp_color = 2'd0; exp_chk = 1'b1;
    b0 = beat_cnt; uk0 = uk_cnt; bc0 = bad_col;
    send_frame(2, -1, 1);
    checks++;
    if ((beat_cnt - b0 != 32) || (uk_cnt - uk0 != 32) || (bad_col - bc0 != 0)) begin
      errors++;
      $display("FAIL unknown_rgb: got beats=%0d unknown=%0d badcol=%0d expected 32 32 0", beat_cnt - b0, uk_cnt - uk0, bad_col - bc0);
    end
  endtask

  task automatic test_reset_mid();
    int b0, fs0;
    exp_color = 2'd3; exp_chk = 1'b1;
    send_seg(0, -1, 1, 0, 0, 4, 8);
    checks++;
    if ((locked_o !== 1'b1) || (err_cnt_o !== 8'd3)) begin
      errors++;
      $display("FAIL rstmid_precond: got lock=%b err_cnt=%0d expected 1 3", locked_o, err_cnt_o);
    end
    #1 arstn = 1'b0;
    #1;
    checks++;
    if ({locked_o, px_valid_o, px_unknown_o, frame_start_o, sync_err_o, err_cnt_o, px_x_o, px_y_o, px_color_o} !== 37'd0) begin
      errors++;
      $display("FAIL rstmid_async_clear: got lock=%b val=%b x=%0d err_cnt=%0d expected all zero", locked_o, px_valid_o, px_x_o, err_cnt_o);
    end
    #1 arstn = 1'b1;
    b0 = beat_cnt; fs0 = fs_cnt;
    send_seg(0, -1, 1, 4, 9, NLINES - 1, LINE);
    send_frame(0, -1, 1);
    checks++;
    if ((locked_o !== 1'b0) || (beat_cnt - b0 != 0)) begin
      errors++;
      $display("FAIL rstmid_no_beats: got lock=%b beats=%0d expected 0 0", locked_o, beat_cnt - b0);
    end
    send_frame(0, -1, 1);
    checks++;
    if ((locked_o !== 1'b1) || (lock_fs - fs0 != 2) || (beat_cnt - b0 != 32) || (err_cnt_o !== 8'd0)) begin
      errors++;
      $display("FAIL rstmid_relock: got lock=%b fs#%0d beats=%0d err_cnt=%0d expected 1 2 32 0", locked_o, lock_fs - fs0, beat_cnt - b0, err_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_lock_green();
    test_pixel();
    test_short_line();
    test_vs_long();
    test_unknown();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
# vga_rx

Capture-side counterpart of the VGA timing generator/framebuffer output. It samples HS, VS and 12-bit RGB in the same `clk` domain and checks the sync timing against the configured mode. Once a full clean frame has been seen it locks, then emits per-pixel (x, y, 2-bit colour code) beats for active-area pixels. Used for loopback self-test of the display path and as a video-capture front end.

## Interface
- HSYNC_BITS, 11: width of horizontal counter and x output
- VSYNC_BITS, 11: width of vertical counter and y output
- HD/HF/HR/HB, 1280/48/112/248: horizontal display, front porch, sync, back porch (cycles)
- VD/VF/VR/VB, 1024/1/3/38: vertical equivalents (lines)
- HMAX, HD+HF+HR+HB-1; VMAX, VD+VF+VR+VB-1
- H_OFFSET, 0: extra cycles between the HS rising edge and the first active RGB beat beyond HR+HB

Ports:
- clk  in  1  pixel clock
- arstn  in  1  reset, asynchronous, active-low
- vga_hs_i  in  1  horizontal sync, active-high
- vga_vs_i  in  1  vertical sync, active-high
- rgb_i  in  12  pixel data
- locked_o  out  1  timing verified, pixel output enabled
- px_valid_o  out  1  active-area pixel beat
- px_x_o  out  HSYNC_BITS  pixel column
- px_y_o  out  VSYNC_BITS  pixel row
- px_color_o  out  2  decoded colour: 0 BLACK, 1 WHITE, 2 BLUE, 3 GREEN
- px_unknown_o  out  1  rgb_i matched no colour code
- frame_start_o  out  1  one-cycle pulse on each frame start
- sync_err_o  out  1  one-cycle pulse on any timing violation
- err_cnt_o  out  8  saturating violation count

## Operation
- Stage 1 registers hs/vs/rgb into hs_q/vs_q/rgb_q. Edges are taken from hs_q versus hs_q delayed by one cycle (same for vs).
- hcnt: cleared to 0 on an HS rise, otherwise increments. Saturates at all-ones.
- vcnt: cleared on a frame start, increments on every other HS rise. Saturates at all-ones.
- Frame start: VS rise in the same cycle as an HS rise.
- Checks, each a violation on failure:
  - at HS rise, previous hcnt == HMAX
  - at HS fall, hcnt == HR
  - at frame start, previous vcnt == VMAX
  - VS falls exactly on the HS rise where vcnt becomes VR
  - VS rise without a coincident HS rise
  - hcnt or vcnt saturated
- FSM:
  - SEARCH: wait for frame start, then go to MEASURE.
  - MEASURE: any violation returns to SEARCH. The next frame start with no violations goes to LOCKED.
  - LOCKED: any violation goes to SEARCH.
- locked_o = (state == LOCKED). A violation is counted and pulsed in any state except SEARCH.
- Active area: hcnt in [HR+HB+H_OFFSET, HR+HB+H_OFFSET+HD) and vcnt in [VR+VB, VR+VB+VD).
  - px_x_o = hcnt-(HR+HB+H_OFFSET); px_y_o = vcnt-(VR+VB).
- Colour decode: 12'h000→0, 12'hFFF→1, 12'hF00→2, 12'h0F0→3. Any other value→0 with px_unknown_o=1.
- err_cnt_o saturates at 255. It is cleared only by reset.

## Timing
- Reset values: all outputs 0; FSM in SEARCH; counters 0.
- Latency: rgb_i sampled at cycle t appears on px_* at t+2. All outputs are registered.
- frame_start_o is aligned with the px_* stage (t+2 of the input HS/VS rise).
- LOCKED entry: locked_o rises in the cycle frame_start_o pulses at the end of the first clean frame.
- px_valid_o goes low in the same cycle as sync_err_o when a violation occurs while locked. No partial-line beats are emitted after that point.
- Violation at the same edge as a frame start: the violation wins; the FSM goes to SEARCH and does not re-arm on that edge.
- Reset mid-frame: outputs clear immediately. Relock needs one full frame start, one clean frame, and a second frame start.

## Structure
- vga_pkg holds:
  - the color enum (BLACK, WHITE, BLUE, GREEN)
  - the 12-bit RGB constants for each colour
  - the rx FSM state enum
- Sub-module vga_rx_sync_tracker contains the input register, edge detect, hcnt/vcnt and violation flags.
- The top level holds the FSM, active-area window, colour decode, error counter and output registers.

## Test plan
Small mode for all scenarios: HD=8, HF=2, HR=2, HB=3, VD=4, VF=1, VR=1, VB=2 (15-cycle line, 8-line frame).
- Three clean frames of GREEN (12'h0F0) → locked_o rises at the second frame start; then exactly 32 px_valid_o beats per frame, x 0..7, y 0..3, px_color_o=3.
- Gradient pattern, then pixel (5,2)=12'hF00 → that beat shows px_x_o=5, px_y_o=2, px_color_o=2, exactly 2 cycles after the input.
- While locked, shorten one line to 14 cycles → sync_err_o pulse, locked_o=0, err_cnt_o=1. Relock after two further clean frame starts.
- VS asserted for 2 lines instead of 1 → violation at the HS rise where vcnt=1; locked_o stays 0 in MEASURE.
- rgb_i=12'h123 in active area → px_color_o=0, px_unknown_o=1.
- arstn pulsed mid-line while locked → all outputs 0 asynchronously; no px_valid_o until the relock sequence completes.
